// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states,
// byte-mask constants and the alignment rule.
package ysyx_23060201_lsu_pkg;

  // RV32 funct3 width/sign codes
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Unshifted 4-lane byte masks
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Halfwords need an even address, words (and undefined codes) a
  // 4-byte aligned one; bytes are always aligned.
  function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic mis;
    case (funct3)
      LSU_B, LSU_BU: mis = 1'b0;
      LSU_H, LSU_HU: mis = off[0];
      default:       mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Combinational lane logic: store data shift and byte mask generation,
// load word extract with sign/zero extension.
module ysyx_23060201_lsu_align
  import ysyx_23060201_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            off,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] wdata_sh,
  output logic [7:0]            wmask,
  output logic [DATA_WIDTH-1:0] rdata_ext
);

  logic [4:0]                   shamt;
  logic [3:0]                   mask4;
  logic [DATA_WIDTH-1:0]        rdata_sh;
  logic signed [7:0]            byte_s;
  logic signed [15:0]           half_s;
  logic signed [DATA_WIDTH-1:0] byte_sx;
  logic signed [DATA_WIDTH-1:0] half_sx;

  assign shamt    = {off, 3'b000};
  assign wdata_sh = wdata << shamt;
  assign rdata_sh = rdata >> shamt;
  assign byte_s   = rdata_sh[7:0];
  assign half_s   = rdata_sh[15:0];
  assign byte_sx  = byte_s;
  assign half_sx  = half_s;
  assign wmask    = {4'b0000, mask4};

  // Byte-enable lanes for the access width, moved to the addressed lane
  always_comb begin
    mask4 = MASK_W;
    case (funct3)
      LSU_B, LSU_BU: mask4 = MASK_B << off;
      LSU_H, LSU_HU: mask4 = MASK_H << off;
      default:       mask4 = MASK_W;
    endcase
  end

  // Extract the addressed bytes from the aligned word and extend them
  always_comb begin
    rdata_ext = rdata_sh;
    case (funct3)
      LSU_B:   rdata_ext = byte_sx;
      LSU_H:   rdata_ext = half_sx;
      LSU_BU:  rdata_ext = {{(DATA_WIDTH-8){1'b0}}, rdata_sh[7:0]};
      LSU_HU:  rdata_ext = {{(DATA_WIDTH-16){1'b0}}, rdata_sh[15:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: one memory operation at a time between EXU and WBU.
// All outputs are registered; misaligned accesses never strobe memory.
module ysyx_23060201_lsu
  import ysyx_23060201_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_misalign
);

  lsu_state_e            state;
  logic                  is_store_r;
  logic [2:0]            funct3_r;
  logic [1:0]            off_r;

  logic [2:0]            al_funct3;
  logic [1:0]            al_off;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [7:0]            al_wmask;
  logic [DATA_WIDTH-1:0] al_rdata;
  logic                  accept;
  logic                  mis;
  logic [ADDR_WIDTH-1:0] addr_al;

  // The store lanes are built from the live request at acceptance; the
  // load extract later uses the latched width and offset.
  assign al_funct3 = (state == ST_IDLE) ? in_funct3    : funct3_r;
  assign al_off    = (state == ST_IDLE) ? in_addr[1:0] : off_r;
  assign accept    = in_valid && in_ready;
  assign mis       = lsu_misaligned(in_funct3, in_addr[1:0]);
  assign addr_al   = {in_addr[ADDR_WIDTH-1:2], 2'b00};

  ysyx_23060201_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3    (al_funct3),
    .off       (al_off),
    .wdata     (in_wdata),
    .rdata     (mem_rdata),
    .wdata_sh  (al_wdata),
    .wmask     (al_wmask),
    .rdata_ext (al_rdata)
  );

  // Request/response FSM with registered memory and WBU side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b1;
      is_store_r   <= 1'b0;
      funct3_r     <= 3'b000;
      off_r        <= 2'b00;
      mem_wen      <= 1'b0;
      mem_ren      <= 1'b0;
      mem_waddr    <= '0;
      mem_raddr    <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= 8'h00;
      out_valid    <= 1'b0;
      out_rdata    <= '0;
      out_misalign <= 1'b0;
    end else begin
      mem_wen <= 1'b0;
      mem_ren <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready   <= 1'b0;
            is_store_r <= in_is_store;
            funct3_r   <= in_funct3;
            off_r      <= in_addr[1:0];
            mem_waddr  <= addr_al;
            mem_raddr  <= addr_al;
            if (mis) begin
              state        <= ST_RESP;
              out_valid    <= 1'b1;
              out_misalign <= 1'b1;
              out_rdata    <= '0;
            end else begin
              state        <= ST_REQ;
              out_misalign <= 1'b0;
              if (in_is_store) begin
                mem_wen   <= 1'b1;
                mem_wdata <= al_wdata;
                mem_wmask <= al_wmask;
              end else begin
                mem_ren <= 1'b1;
              end
            end
          end
        end
        ST_REQ: begin
          if (is_store_r) begin
            state     <= ST_RESP;
            out_valid <= 1'b1;
            out_rdata <= '0;
          end else begin
            state <= ST_WAIT_R;
          end
        end
        ST_WAIT_R: begin
          if (mem_rvalid) begin
            state     <= ST_RESP;
            out_valid <= 1'b1;
            out_rdata <= al_rdata;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Directed bench for the load/store unit: a vector table of single
// operations plus hand-written stall and mid-load reset sequences.
module tb_ysyx_23060201_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_misalign;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int wen_cnt  = 0;
  int ren_cnt  = 0;

  ysyx_23060201_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_store  (in_is_store),
    .in_funct3    (in_funct3),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .mem_wen      (mem_wen),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_ren      (mem_ren),
    .mem_raddr    (mem_raddr),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rdata    (out_rdata),
    .out_misalign (out_misalign)
  );

  always #5 clk = ~clk;

  // Count memory strobes seen at each active edge
  always @(posedge clk) begin
    if (mem_wen) wen_cnt <= wen_cnt + 1;
    if (mem_ren) ren_cnt <= ren_cnt + 1;
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic        mis;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [7:0]  e_mask;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   w0;
    int   r0;
    v  = vecs[i];
    w0 = wen_cnt;
    r0 = ren_cnt;
    in_valid    = 1'b1;
    in_is_store = v.st;
    in_funct3   = v.f3;
    in_addr     = v.addr;
    in_wdata    = v.wdata;
    out_ready   = 1'b1;
    tick();
    in_valid = 1'b0;
    chk($sformatf("v%0d in_ready_busy", i), {31'd0, in_ready}, 32'd0);
    if (v.mis) begin
      chk($sformatf("v%0d mis_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d mis_flag", i), {31'd0, out_misalign}, 32'd1);
      chk($sformatf("v%0d mis_rdata", i), out_rdata, 32'd0);
    end else if (v.st) begin
      chk($sformatf("v%0d wen", i), {31'd0, mem_wen}, 32'd1);
      chk($sformatf("v%0d ren_low", i), {31'd0, mem_ren}, 32'd0);
      chk($sformatf("v%0d waddr", i), mem_waddr, v.e_addr);
      chk($sformatf("v%0d wdata", i), mem_wdata, v.e_wdata);
      chk($sformatf("v%0d wmask", i), {24'd0, mem_wmask}, {24'd0, v.e_mask});
      chk($sformatf("v%0d early_valid", i), {31'd0, out_valid}, 32'd0);
      tick();
      chk($sformatf("v%0d wen_drop", i), {31'd0, mem_wen}, 32'd0);
      chk($sformatf("v%0d st_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d st_rdata", i), out_rdata, 32'd0);
      chk($sformatf("v%0d st_misalign", i), {31'd0, out_misalign}, 32'd0);
    end else begin
      chk($sformatf("v%0d ren", i), {31'd0, mem_ren}, 32'd1);
      chk($sformatf("v%0d wen_low", i), {31'd0, mem_wen}, 32'd0);
      chk($sformatf("v%0d raddr", i), mem_raddr, v.e_addr);
      tick();
      chk($sformatf("v%0d ren_drop", i), {31'd0, mem_ren}, 32'd0);
      for (int k = 1; k < v.dly; k++) begin
        chk($sformatf("v%0d wait_valid", i), {31'd0, out_valid}, 32'd0);
        tick();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h5A5A_5A5A;
      chk($sformatf("v%0d ld_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d ld_rdata", i), out_rdata, v.e_rdata);
      chk($sformatf("v%0d ld_misalign", i), {31'd0, out_misalign}, 32'd0);
    end
    tick();
    chk($sformatf("v%0d done_valid", i), {31'd0, out_valid}, 32'd0);
    chk($sformatf("v%0d done_ready", i), {31'd0, in_ready}, 32'd1);
    chk($sformatf("v%0d wen_pulses", i), wen_cnt - w0, (v.st && !v.mis) ? 32'd1 : 32'd0);
    chk($sformatf("v%0d ren_pulses", i), ren_cnt - r0, (!v.st && !v.mis) ? 32'd1 : 32'd0);
  endtask

  initial begin
    //            st    f3      addr          wdata         rdata         dly mis   e_addr        e_wdata       e_mask  e_rdata
    vecs[0]  = '{1'b1, 3'b000, 32'h80000003, 32'h000000AB, 32'h00000000, 0, 1'b0, 32'h80000000, 32'hAB000000, 8'h08, 32'h00000000};
    vecs[1]  = '{1'b0, 3'b001, 32'h80000002, 32'h00000000, 32'h80011234, 3, 1'b0, 32'h80000000, 32'h00000000, 8'h00, 32'hFFFF8001};
    vecs[2]  = '{1'b0, 3'b101, 32'h80000002, 32'h00000000, 32'h80011234, 3, 1'b0, 32'h80000000, 32'h00000000, 8'h00, 32'h00008001};
    vecs[3]  = '{1'b1, 3'b010, 32'h80000006, 32'h11223344, 32'h00000000, 0, 1'b1, 32'h00000000, 32'h00000000, 8'h00, 32'h00000000};
    vecs[4]  = '{1'b1, 3'b001, 32'h80000000, 32'h0000BEEF, 32'h00000000, 0, 1'b0, 32'h80000000, 32'h0000BEEF, 8'h03, 32'h00000000};
    vecs[5]  = '{1'b0, 3'b000, 32'h80000001, 32'h00000000, 32'h0000EF00, 1, 1'b0, 32'h80000000, 32'h00000000, 8'h00, 32'hFFFFFFEF};
    vecs[6]  = '{1'b0, 3'b100, 32'h80000003, 32'h00000000, 32'h9C000000, 2, 1'b0, 32'h80000000, 32'h00000000, 8'h00, 32'h0000009C};
    vecs[7]  = '{1'b0, 3'b000, 32'h80000003, 32'h00000000, 32'h9C000000, 1, 1'b0, 32'h80000000, 32'h00000000, 8'h00, 32'hFFFFFF9C};
    vecs[8]  = '{1'b0, 3'b010, 32'h80000004, 32'h00000000, 32'hDEADBEEF, 2, 1'b0, 32'h80000004, 32'h00000000, 8'h00, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 3'b001, 32'h80000002, 32'h00001234, 32'h00000000, 0, 1'b0, 32'h80000000, 32'h12340000, 8'h0C, 32'h00000000};
    vecs[10] = '{1'b0, 3'b001, 32'h80000001, 32'h00000000, 32'h00000000, 0, 1'b1, 32'h00000000, 32'h00000000, 8'h00, 32'h00000000};
    vecs[11] = '{1'b1, 3'b010, 32'h80000008, 32'hCAFEBABE, 32'h00000000, 0, 1'b0, 32'h80000008, 32'hCAFEBABE, 8'h0F, 32'h00000000};
    vecs[12] = '{1'b0, 3'b101, 32'h80000003, 32'h00000000, 32'h00000000, 0, 1'b1, 32'h00000000, 32'h00000000, 8'h00, 32'h00000000};
    vecs[13] = '{1'b0, 3'b001, 32'h80000000, 32'h00000000, 32'h12347FFF, 1, 1'b0, 32'h80000000, 32'h00000000, 8'h00, 32'h00007FFF};
    vecs[14] = '{1'b1, 3'b000, 32'h80000001, 32'h0000005A, 32'h00000000, 0, 1'b0, 32'h80000000, 32'h00005A00, 8'h02, 32'h00000000};

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_is_store = 1'b0;
    in_funct3   = 3'b000;
    in_addr     = 32'h0;
    in_wdata    = 32'h0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    out_ready   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst mem_ren", {31'd0, mem_ren}, 32'd0);
    chk("rst out_rdata", out_rdata, 32'd0);
    chk("rst out_misalign", {31'd0, out_misalign}, 32'd0);
    chk("rst mem_wmask", {24'd0, mem_wmask}, 32'd0);
    chk("rst mem_waddr", mem_waddr, 32'd0);

    // A read response while idle must be ignored
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    tick();
    mem_rvalid = 1'b0;
    chk("idle rvalid out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle rvalid in_ready", {31'd0, in_ready}, 32'd1);

    // Table vectors, issued back to back
    for (int i = 0; i < NV; i++) run_vec(i);

    // LW with the WBU stalling for five cycles
    in_valid    = 1'b1;
    in_is_store = 1'b0;
    in_funct3   = 3'b010;
    in_addr     = 32'h80000010;
    out_ready   = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d out_rdata", k), out_rdata, 32'h12345678);
      chk($sformatf("stall%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("stall release out_valid", {31'd0, out_valid}, 32'd0);
    chk("stall release in_ready", {31'd0, in_ready}, 32'd1);

    // Reset while a load waits for its data; the late response is dropped
    in_valid    = 1'b1;
    in_is_store = 1'b0;
    in_funct3   = 3'b010;
    in_addr     = 32'h80000020;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst out_rdata", out_rdata, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5A5A5;
    tick();
    mem_rvalid = 1'b0;
    chk("late rvalid out_valid", {31'd0, out_valid}, 32'd0);
    chk("late rvalid in_ready", {31'd0, in_ready}, 32'd1);
    chk("late rvalid out_rdata", out_rdata, 32'd0);
    tick();
    chk("late rvalid out_valid2", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
